memory_responder: RTL and testbench

// - Responder end of the core's memory handshake (memory_enable/memory_command/memory_ready/memory_valid).
// - Owns a word-organised on-chip RAM and serves instruction fetches, loads and stores issued by the multicycle controller.
// - Makes one access at a time, with a fixed, parameterised wait-state latency.

---
 rtl/memory_responder.sv | 153 +++++++++++++++
 tb/tb_memory_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Single-port word RAM behind the core's enable/ready/valid memory handshake.
// Optional range checking with access_fault: MEMORY_RESPONDER_ACCESS_FAULT_EN.
module memory_responder #(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter int unsigned LATENCY      = 1,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] read_data,
  output logic        access_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESPOND
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_cmd;
  logic [AW-1:0] r_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0] w_off;
  logic        w_accept;
  logic        w_enter;
  logic        w_live;
  logic        w_cmd;
  logic [AW-1:0] w_idx;
  logic [31:0] w_wdata;
  logic [3:0]  w_strb;
  logic        w_flt;
  logic        w_unused;

  assign w_off    = address - BASE_ADDRESS;
  assign w_unused = ^{w_off[1:0], w_off[31:AW+2]};
  assign w_accept = memory_ready & memory_enable;

  // With LATENCY=1 the array is touched on the accept edge itself,
  // so the live request is used before the capture registers load.
  assign w_live  = (r_state == S_IDLE);
  assign w_cmd   = w_live ? memory_command : r_cmd;
  assign w_idx   = w_live ? w_off[AW+1:2] : r_idx;
  assign w_wdata = w_live ? write_data : r_wdata;
  assign w_strb  = w_live ? write_strobe : r_strb;

  assign w_enter =
    ((r_state == S_IDLE) & w_accept & (LATENCY == 1)) |
    ((r_state == S_BUSY) & (r_cnt == 4'd0));

`ifdef MEMORY_RESPONDER_ACCESS_FAULT_EN
  logic r_fault;
  logic w_fault_in;

  assign w_fault_in = (w_off >= 32'(4 * DEPTH_WORDS));
  assign w_flt      = w_live ? w_fault_in : r_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_fault <= w_fault_in;
    end
  end

  assign access_fault = memory_valid & r_fault;
`else
  assign w_flt        = 1'b0;
  assign access_fault = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_next = S_RESPOND;
          end else begin
            w_next     = S_BUSY;
            w_cnt_next = CNT_INIT;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_next = S_RESPOND;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESPOND: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cmd   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_cmd   <= memory_command;
        r_idx   <= w_off[AW+1:2];
        r_wdata <= write_data;
        r_strb  <= write_strobe;
      end
      r_rdata <= (w_enter & ~w_cmd & ~w_flt) ? r_mem[w_idx] : '0;
    end
  end

  // RAM contents survive reset; an aborted write never reaches here.
  always_ff @(posedge clk) begin
    if (~reset & w_enter & w_cmd & ~w_flt) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  assign memory_ready = ~reset & (r_state == S_IDLE);
  assign memory_valid = ~reset & (r_state == S_RESPOND);
  assign read_data    = reset ? 32'd0 : r_rdata;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench: LATENCY=3 and LATENCY=1 responders, 16-word RAMs.
// Issued requests push expectations; per-DUT monitors pop on memory_valid.
module tb_memory_responder;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_n = 0;
  int chk_n  = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic        a_en = 1'b0, a_cmd = 1'b0;
  logic [31:0] a_addr = '0, a_wd = '0;
  logic [3:0]  a_ws = '0;
  logic        a_rdy, a_vld, a_flt;
  logic [31:0] a_rd;

  logic        b_en = 1'b0, b_cmd = 1'b0;
  logic [31:0] b_addr = '0, b_wd = '0;
  logic [3:0]  b_ws = '0;
  logic        b_rdy, b_vld, b_flt;
  logic [31:0] b_rd;

  memory_responder #(
    .DEPTH_WORDS(16), .LATENCY(3), .BASE_ADDRESS(32'h0)
  ) u_dut_a (
    .clk(clk), .reset(rst),
    .memory_enable(a_en), .memory_command(a_cmd),
    .address(a_addr), .write_data(a_wd), .write_strobe(a_ws),
    .memory_ready(a_rdy), .memory_valid(a_vld),
    .read_data(a_rd), .access_fault(a_flt)
  );

  memory_responder #(
    .DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDRESS(32'h0)
  ) u_dut_b (
    .clk(clk), .reset(rst),
    .memory_enable(b_en), .memory_command(b_cmd),
    .address(b_addr), .write_data(b_wd), .write_strobe(b_ws),
    .memory_ready(b_rdy), .memory_valid(b_vld),
    .read_data(b_rd), .access_fault(b_flt)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    chk_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (a_vld) begin
      if (qa.size() == 0) begin
        check("a_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_read_data", a_rd, e.data);
        check("a_fault", 32'(a_flt), 32'(e.fault));
        check("a_valid_cycle", 32'(cyc), 32'(e.due));
        check("a_ready_in_valid", 32'(a_rdy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (b_vld) begin
      if (qb.size() == 0) begin
        check("b_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_read_data", b_rd, e.data);
        check("b_fault", 32'(b_flt), 32'(e.fault));
        check("b_valid_cycle", 32'(cyc), 32'(e.due));
        check("b_ready_in_valid", 32'(b_rdy), 32'd0);
      end
    end
  end

  task automatic issue_a(input logic c, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input logic [31:0] ed, input logic ef,
                         input bit push);
    int n = 0;
    while (!a_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("a_ready_before_issue", 32'(a_rdy), 32'd1);
    if (!a_rdy) return;
    a_en = 1'b1; a_cmd = c; a_addr = ad; a_wd = wd; a_ws = ws;
    if (push) qa.push_back('{ed, ef, cyc + 3});
    @(negedge clk);
    a_en = 1'b0; a_addr = 32'hFFFF_FFFC; a_wd = 32'h5A5A_5A5A;
    check("a_ready_after_accept", 32'(a_rdy), 32'd0);
  endtask

  task automatic issue_b(input logic c, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input logic [31:0] ed, output int acc);
    int n = 0;
    acc = -1;
    while (!b_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b_ready_before_issue", 32'(b_rdy), 32'd1);
    if (!b_rdy) return;
    b_en = 1'b1; b_cmd = c; b_addr = ad; b_wd = wd; b_ws = ws;
    qb.push_back('{ed, 1'b0, cyc + 1});
    acc = cyc + 1;
    @(negedge clk);
    b_en = 1'b0; b_addr = 32'hFFFF_FFFC; b_wd = 32'hA5A5_A5A5;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(qa.size() + qb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int acc0, acc1, acc2, nacc;

    repeat (2) @(negedge clk);
    check("rst_a_ready", 32'(a_rdy), 32'd0);
    check("rst_a_valid", 32'(a_vld), 32'd0);
    check("rst_a_rdata", a_rd, 32'd0);
    check("rst_a_fault", 32'(a_flt), 32'd0);
    check("rst_b_ready", 32'(b_rdy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_a_ready", 32'(a_rdy), 32'd1);
    check("post_rst_b_ready", 32'(b_rdy), 32'd1);

    // Full word, partial strobe, and empty strobe writes
    issue_a(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1);
    issue_a(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue_a(1'b1, 32'h10, 32'h0000_AB00, 4'b0010, 32'h0, 1'b0, 1'b1);
    issue_a(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_ABEF, 1'b0, 1'b1);
    issue_a(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 1'b1);
    issue_a(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_ABEF, 1'b0, 1'b1);
    drain();

    // Enable held high: one accept per LATENCY+1 cycles
    nacc = 0;
    a_en = 1'b1; a_cmd = 1'b0; a_addr = 32'h10;
    for (int i = 0; i < 12; i++) begin
      if (a_rdy) begin
        qa.push_back('{32'hDEAD_ABEF, 1'b0, cyc + 3});
        nacc++;
      end
      @(negedge clk);
    end
    a_en = 1'b0;
    check("hold_accept_count", 32'(nacc), 32'd3);
    drain();

    // Reset in BUSY aborts a write
    issue_a(1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 1'b1);
    issue_a(1'b0, 32'h20, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
    drain();
    issue_a(1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_a_ready", 32'(a_rdy), 32'd0);
    check("mid_rst_a_valid", 32'(a_vld), 32'd0);
    check("mid_rst_a_rdata", a_rd, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("after_abort_ready", 32'(a_rdy), 32'd1);
    issue_a(1'b0, 32'h20, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
    drain();

    // Out-of-range read on a 16-word RAM
    issue_a(1'b1, 32'h0, 32'hCAFE_0001, 4'hF, 32'h0, 1'b0, 1'b1);
`ifdef MEMORY_RESPONDER_ACCESS_FAULT_EN
    issue_a(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
`else
    issue_a(1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 1'b1);
`endif
    drain();

    // LATENCY=1 back-to-back fetches
    issue_b(1'b1, 32'h0, 32'h1111_1111, 4'hF, 32'h0, acc0);
    issue_b(1'b1, 32'h4, 32'h2222_2222, 4'hF, 32'h0, acc0);
    issue_b(1'b1, 32'h8, 32'h3333_3333, 4'hF, 32'h0, acc0);
    issue_b(1'b0, 32'h0, 32'h0, 4'h0, 32'h1111_1111, acc0);
    issue_b(1'b0, 32'h4, 32'h0, 4'h0, 32'h2222_2222, acc1);
    issue_b(1'b0, 32'h8, 32'h0, 4'h0, 32'h3333_3333, acc2);
    check("b_spacing_01", 32'(acc1 - acc0), 32'd2);
    check("b_spacing_12", 32'(acc2 - acc1), 32'd2);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
